// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path.
//   - ps2_state_t : receiver FSM states
//   - frame constants (start/stop levels, data width)
//   - common scan codes used by the downstream hold-tracking stage
//   - odd_parity_ok(): frame parity check helper
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam logic [7:0] BREAK_CODE    = 8'hF0;
    localparam logic [7:0] EXTENDED_CODE = 8'hE0;
    localparam logic [7:0] KEY_SPACE     = 8'h29;
    localparam logic [7:0] KEY_W         = 8'h1D;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer followed by a stability filter.
// The filtered output only follows the synchronized line after FILTER_CYCLES
// consecutive samples that all differ from the current filtered level.
// Ports:
//   Clock    - system clock
//   reset    - asynchronous active-low reset (output and flops go to RESET_VALUE)
//   line     - raw asynchronous input line
//   filtered - synchronized, glitch-filtered level
module ps2_line_filter #(
    parameter int   FILTER_CYCLES = 8,
    parameter logic RESET_VALUE   = 1'b1
) (
    input  logic Clock,
    input  logic reset,
    input  logic line,
    output logic filtered
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync_p0    <= RESET_VALUE;
            sync_p1    <= RESET_VALUE;
            filtered   <= RESET_VALUE;
            stable_cnt <= '0;
        end else begin
            // Stage p0/p1: metastability synchronizer
            sync_p0 <= line;
            sync_p1 <= sync_p0;

            // Filter stage: any sample matching the current level restarts the run.
            if (sync_p1 == filtered) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                filtered   <= sync_p1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: receive-only PS/2 device-to-host deserializer.
// Decodes 11-bit frames (start, 8 data bits LSB first, odd parity, stop) and
// emits each good byte with a one-cycle rx_valid strobe. Parity, start/stop
// framing and inter-edge timeout failures give a one-cycle rx_error strobe.
// The PS/2 lines are only ever read.
// Ports:
//   Clock    - system clock, all logic on rising edge
//   reset    - asynchronous active-low reset
//   PS2_CLK  - raw PS/2 clock line (idle high)
//   PS2_DAT  - raw PS/2 data line (idle high)
//   rx_data  - last correctly received byte
//   rx_valid - one-cycle strobe, rx_data updated this cycle
//   rx_error - one-cycle strobe on a failed or abandoned frame
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int FILTER_CYCLES   = 8,
    parameter int TIMEOUT_US      = 200
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    logic                 clk_filt;
    logic                 clk_filt_dly;
    logic                 fall_p2;
    logic                 dat_p0;
    logic                 dat_p1;

    ps2_state_t           state;
    logic [2:0]           bit_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    ps2_line_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_VALUE   (1'b1)
    ) u_clk_filter (
        .Clock    (Clock),
        .reset    (reset),
        .line     (PS2_CLK),
        .filtered (clk_filt)
    );

    // Data line: synchronize only. By the time a filtered clock fall is seen
    // the data line has been stable for many cycles.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            dat_p0       <= 1'b1;
            dat_p1       <= 1'b1;
            clk_filt_dly <= 1'b1;
            fall_p2      <= 1'b0;
        end else begin
            dat_p0       <= PS2_DAT;
            dat_p1       <= dat_p0;
            // Fall event stage: registered 1->0 transition, exactly one cycle wide
            clk_filt_dly <= clk_filt;
            fall_p2      <= clk_filt_dly & ~clk_filt;
        end
    end

    // Frame payload capture; no reset needed since a frame always rewrites
    // every bit before it can be delivered.
    always_ff @(posedge Clock) begin
        if (fall_p2) begin
            if (state == DATA) begin
                shift_reg[bit_cnt] <= dat_p1;
            end
            if (state == PARITY) begin
                parity_bit <= dat_p1;
            end
        end
    end

    // Frame FSM with registered strobes
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;

            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall_p2 && dat_p1 == START_BIT) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (fall_p2) begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                    end
                    default: begin
                        if (dat_p1 == STOP_BIT && odd_parity_ok(shift_reg, parity_bit)) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                // Device stalled mid-frame: abandon the partial byte.
                rx_error <= 1'b1;
                state    <= IDLE;
                bit_cnt  <= '0;
                to_cnt   <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule
